// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life MAX7219 display driver.
//  - MAX7219 register addresses
//  - top-level sequencing states and per-word serial sub-phases
//  - the power-up init word table
package gol_pkg;

  localparam logic [7:0] DIGIT0    = 8'h01;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIM   = 8'h0B;
  localparam logic [7:0] SHUTDN    = 8'h0C;
  localparam logic [7:0] DISPTEST  = 8'h0F;

  localparam int INIT_WORDS = 5;
  localparam int ROWS       = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    PH_LOW   = 2'd0,
    PH_HIGH  = 2'd1,
    PH_LATCH = 2'd2,
    PH_GAP   = 2'd3
  } phase_e;

  // Init sequence: leave shutdown, scan all 8 digits, raw (no BCD decode),
  // set brightness, leave display-test mode.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    init_word = {SHUTDN, 8'h01};
      3'd1:    init_word = {SCANLIM, 8'h07};
      3'd2:    init_word = {DECODE, 8'h00};
      3'd3:    init_word = {INTENSITY, 4'h0, inten};
      3'd4:    init_word = {DISPTEST, 8'h00};
      default: init_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/gol_max7219_driver_if.sv
// MAX7219 three-wire serial bus.
//  cs_n : LOAD/CS, low for the duration of each word
//  sck  : serial clock, idles low
//  din  : serial data, MSB first
// master = driver side, slave = display/monitor side.
interface gol_max7219_driver_if;
  logic cs_n;
  logic sck;
  logic din;

  modport master (output cs_n, output sck, output din);
  modport slave  (input cs_n, input sck, input din);
endinterface

// File: rtl/gol_spi_word_tx.sv
// Serialises one 16-bit MAX7219 word.
//  clka, reset : system clock, async active-high reset
//  start       : 1-cycle request, accepted when idle or in the final GAP cycle
//  word        : {addr, data}, sent bit15 first
//  done        : 1-cycle pulse in the final GAP cycle
//  cs_n/sck/din: registered serial outputs
// Each bit is LOW then HIGH for CLK_DIV cycles each, followed by LATCH and GAP,
// giving 34*CLK_DIV cycles per word. Accepting start in the final GAP cycle lets
// the parent chain words with no idle cycle in between.
module gol_spi_word_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        cs_n,
  output logic        sck,
  output logic        din
);
  import gol_pkg::*;

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic          active, active_n;
  phase_e        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bidx, bidx_n;
  logic [15:0]   sh, sh_n;
  logic          last, ready;

  assign last  = (cnt == CNT_LAST);
  assign done  = active && (phase == PH_GAP) && last;
  assign ready = !active || done;

  always_comb begin
    active_n = active;
    phase_n  = phase;
    cnt_n    = cnt;
    bidx_n   = bidx;
    sh_n     = sh;
    if (start && ready) begin
      active_n = 1'b1;
      phase_n  = PH_LOW;
      cnt_n    = '0;
      bidx_n   = 4'd15;
      sh_n     = word;
    end else if (active) begin
      if (!last) begin
        cnt_n = cnt + CW'(1);
      end else begin
        cnt_n = '0;
        case (phase)
          PH_LOW:  phase_n = PH_HIGH;
          PH_HIGH: begin
            if (bidx == 4'd0) begin
              phase_n = PH_LATCH;
            end else begin
              phase_n = PH_LOW;
              bidx_n  = bidx - 4'd1;
              sh_n    = {sh[14:0], 1'b0};
            end
          end
          PH_LATCH: phase_n = PH_GAP;
          default:  active_n = 1'b0;
        endcase
      end
    end
  end

  // Control state and registered pin outputs
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      phase  <= PH_LOW;
      cnt    <= '0;
      bidx   <= 4'd15;
      cs_n   <= 1'b1;
      sck    <= 1'b0;
      din    <= 1'b0;
    end else begin
      active <= active_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      bidx   <= bidx_n;
      cs_n   <= !(active_n && (phase_n != PH_GAP));
      sck    <= active_n && (phase_n == PH_HIGH);
      din    <= active_n && ((phase_n == PH_LOW) || (phase_n == PH_HIGH)) && sh_n[15];
    end
  end

  // Shift register is pure data; gated by active/phase on the way out
  always_ff @(posedge clka) begin
    sh <= sh_n;
  end

endmodule

// File: rtl/gol_max7219_driver.sv
// Drives an 8x8 LED matrix through a MAX7219 from the Game of Life cell grid.
//  clka, reset : system clock, async active-high reset
//  grid        : 64 cells, row r = grid[8r+7:8r]
//  update      : frame refresh request, level sampled each cycle
//  busy        : high during init or frame transmission
//  frame_done  : 1-cycle pulse in the final GAP cycle of the 8th row word
//  spi         : MAX7219 serial bus (cs_n, sck, din)
// Sends the 5-word init sequence after reset, then one 8-word frame per request.
// Requests arriving while busy coalesce into a single pending frame.
module gol_max7219_driver #(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic        clka,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        update,
  output logic        busy,
  output logic        frame_done,
  gol_max7219_driver_if.master spi
);
  import gol_pkg::*;

  top_state_e  state, state_n;
  logic [2:0]  widx, widx_n;
  logic        first, first_n;
  logic        pending, pending_n;
  logic [63:0] snap;
  logic        snap_load;
  logic        tx_start, tx_done;
  logic [15:0] tx_word;
  logic [2:0]  sel;
  logic [63:0] row_src;
  logic [7:0]  row_data;
  logic [7:0]  row_addr;

  // first marks the opening word of a sequence, when the serialiser is idle;
  // otherwise the next word is launched on the done pulse of the current one.
  assign sel      = first ? widx : widx + 3'd1;
  // On a chained frame the snapshot is loaded on the same edge as the first
  // row word, so that word takes its data straight from grid.
  assign row_src  = (!first && (widx == 3'(ROWS - 1))) ? grid : snap;
  assign row_data = row_src[{sel, 3'b000} +: 8];
  assign row_addr = DIGIT0 + {5'b00000, sel};
  assign tx_word  = (state == ST_INIT) ? init_word(sel, INTENSITY) : {row_addr, row_data};
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    widx_n     = widx;
    first_n    = first;
    pending_n  = pending;
    snap_load  = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_INIT: begin
        if (update) pending_n = 1'b1;
        if (first) begin
          tx_start = 1'b1;
          first_n  = 1'b0;
        end else if (tx_done) begin
          if (widx == 3'(INIT_WORDS - 1)) begin
            state_n = ST_IDLE;
            widx_n  = 3'd0;
          end else begin
            tx_start = 1'b1;
            widx_n   = sel;
          end
        end
      end
      ST_IDLE: begin
        if (update || pending) begin
          state_n   = ST_FRAME;
          snap_load = 1'b1;
          widx_n    = 3'd0;
          first_n   = 1'b1;
          pending_n = 1'b0;
        end
      end
      ST_FRAME: begin
        if (update) pending_n = 1'b1;
        if (first) begin
          tx_start = 1'b1;
          first_n  = 1'b0;
        end else if (tx_done) begin
          if (widx != 3'(ROWS - 1)) begin
            tx_start = 1'b1;
            widx_n   = sel;
          end else begin
            frame_done = 1'b1;
            widx_n     = 3'd0;
            if (pending || update) begin
              tx_start  = 1'b1;
              snap_load = 1'b1;
              pending_n = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // Sequencing control
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      widx    <= 3'd0;
      first   <= 1'b1;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      widx    <= widx_n;
      first   <= first_n;
      pending <= pending_n;
    end
  end

  // Frame snapshot (data only)
  always_ff @(posedge clka) begin
    if (snap_load) snap <= grid;
  end

  gol_spi_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clka  (clka),
    .reset (reset),
    .start (tx_start),
    .word  (tx_word),
    .done  (tx_done),
    .cs_n  (spi.cs_n),
    .sck   (spi.sck),
    .din   (spi.din)
  );

endmodule

// File: tb/tb_gol_max7219_driver.sv
module tb_gol_max7219_driver;

  logic        clk = 1'b0;
  logic        rst2 = 1'b0, rst1 = 1'b0;
  logic [63:0] grid2 = 64'h0, grid1 = 64'h0;
  logic        update2 = 1'b0, update1 = 1'b0;
  logic        busy2, busy1, fd2, fd1;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  gol_max7219_driver_if spi2();
  gol_max7219_driver_if spi1();

  gol_max7219_driver #(.CLK_DIV(2), .INTENSITY(4'h8)) dut2 (
    .clka(clk), .reset(rst2), .grid(grid2), .update(update2),
    .busy(busy2), .frame_done(fd2), .spi(spi2));

  gol_max7219_driver #(.CLK_DIV(1), .INTENSITY(4'h3)) dut1 (
    .clka(clk), .reset(rst1), .grid(grid1), .update(update1),
    .busy(busy1), .frame_done(fd1), .spi(spi1));

  always #5 clk = ~clk;

  // Bus decoders: a word is accepted only if 16 sck rises occurred while cs_n was low.
  logic [15:0] wq2[$], wq1[$];
  int          lq2[$], lq1[$];
  int          fdt2[$], fdt1[$];
  int          fdcnt2 = 0, fdcnt1 = 0;
  int          nb2 = 0, nb1 = 0, low2 = 0, low1 = 0;
  logic [15:0] sh2 = 16'h0, sh1 = 16'h0;
  logic        cs2_prev = 1'b1, sck2_prev = 1'b0, cs1_prev = 1'b1, sck1_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (spi2.cs_n === 1'b0) begin
      low2++;
      if (spi2.sck === 1'b1 && sck2_prev === 1'b0) begin sh2 = {sh2[14:0], spi2.din}; nb2++; end
    end
    if (spi2.cs_n === 1'b1 && cs2_prev === 1'b0) begin
      if (nb2 == 16) begin wq2.push_back(sh2); lq2.push_back(low2); end
      nb2 = 0; low2 = 0;
    end
    if (fd2 === 1'b1) begin fdcnt2++; fdt2.push_back(cyc); end
    cs2_prev = spi2.cs_n; sck2_prev = spi2.sck;

    if (spi1.cs_n === 1'b0) begin
      low1++;
      if (spi1.sck === 1'b1 && sck1_prev === 1'b0) begin sh1 = {sh1[14:0], spi1.din}; nb1++; end
    end
    if (spi1.cs_n === 1'b1 && cs1_prev === 1'b0) begin
      if (nb1 == 16) begin wq1.push_back(sh1); lq1.push_back(low1); end
      nb1 = 0; low1 = 0;
    end
    if (fd1 === 1'b1) begin fdcnt1++; fdt1.push_back(cyc); end
    cs1_prev = spi1.cs_n; sck1_prev = spi1.sck;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle2(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (busy2 === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int t_fall, t_idle, bad;
    logic [15:0] got;
    logic [15:0] exp2 [5];
    logic [15:0] exp1 [5];
    exp2 = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00};
    exp1 = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A03, 16'h0F00};
    #1;
    rst2 = 1'b1; rst1 = 1'b1;
    repeat (3) tick();
    nvec++; if (spi2.cs_n !== 1'b1) begin nfail++; $display("FAIL reset_cs_n: got %b want 1", spi2.cs_n); end
    nvec++; if (spi2.sck !== 1'b0) begin nfail++; $display("FAIL reset_sck: got %b want 0", spi2.sck); end
    nvec++; if (spi2.din !== 1'b0) begin nfail++; $display("FAIL reset_din: got %b want 0", spi2.din); end
    nvec++; if (busy2 !== 1'b1) begin nfail++; $display("FAIL reset_busy: got %b want 1", busy2); end
    nvec++; if (fd2 !== 1'b0) begin nfail++; $display("FAIL reset_frame_done: got %b want 0", fd2); end
    wq2.delete(); lq2.delete(); wq1.delete(); lq1.delete();
    rst2 = 1'b0; rst1 = 1'b0;
    t_fall = -1; t_idle = -1;
    for (int i = 0; i < 1000 && t_idle < 0; i++) begin
      tick();
      if (t_fall < 0 && spi2.cs_n === 1'b0) t_fall = i;
      if (t_fall >= 0 && busy2 === 1'b0) t_idle = i;
    end
    nvec++; if (t_idle < 0) begin nfail++; $display("FAIL init_timeout: busy still %b want 0", busy2); end
    nvec++; if (t_idle - t_fall != 340) begin nfail++; $display("FAIL init_length: got %0d cycles want 340", t_idle - t_fall); end
    nvec++; if (wq2.size() != 5) begin nfail++; $display("FAIL init_word_count: got %0d want 5", wq2.size()); end
    for (int k = 0; k < 5; k++) begin
      got = (k < wq2.size()) ? wq2[k] : 16'hxxxx;
      nvec++; if (got !== exp2[k]) begin nfail++; $display("FAIL init_word%0d: got %h want %h", k, got, exp2[k]); end
    end
    bad = 0;
    foreach (lq2[k]) if (lq2[k] != 66) bad++;
    nvec++; if (bad != 0 || lq2.size() != 5) begin nfail++; $display("FAIL init_cs_window: %0d of %0d windows not 66 cycles", bad, lq2.size()); end
    for (int k = 0; k < 5; k++) begin
      got = (k < wq1.size()) ? wq1[k] : 16'hxxxx;
      nvec++; if (got !== exp1[k]) begin nfail++; $display("FAIL init1_word%0d: got %h want %h", k, got, exp1[k]); end
    end
    nvec++; if (busy1 !== 1'b0) begin nfail++; $display("FAIL init1_busy: got %b want 0", busy1); end
  endtask

  task automatic test_frame();
    int t_cs, t_fd, t_idle;
    logic [15:0] got;
    logic [15:0] exp_w [8];
    exp_w = '{16'h01A5, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    wq2.delete(); lq2.delete(); fdt2.delete(); fdcnt2 = 0;
    grid2 = 64'h0000_0000_0000_00A5;
    update2 = 1'b1; tick(); update2 = 1'b0;
    t_cs = -1; t_fd = -1; t_idle = -1;
    for (int i = 0; i < 2000 && t_idle < 0; i++) begin
      tick();
      if (t_cs < 0 && spi2.cs_n === 1'b0) t_cs = i;
      if (t_fd < 0 && fd2 === 1'b1) t_fd = i;
      if (t_fd >= 0 && busy2 === 1'b0) t_idle = i;
    end
    nvec++; if (t_idle < 0) begin nfail++; $display("FAIL frame_timeout: busy %b want 0", busy2); end
    nvec++; if (t_fd - t_cs != 543) begin nfail++; $display("FAIL frame_done_time: got %0d want 543", t_fd - t_cs); end
    nvec++; if (t_idle - t_fd != 1) begin nfail++; $display("FAIL frame_busy_fall: got %0d want 1", t_idle - t_fd); end
    nvec++; if (wq2.size() != 8) begin nfail++; $display("FAIL frame_word_count: got %0d want 8", wq2.size()); end
    for (int k = 0; k < 8; k++) begin
      got = (k < wq2.size()) ? wq2[k] : 16'hxxxx;
      nvec++; if (got !== exp_w[k]) begin nfail++; $display("FAIL frame_word%0d: got %h want %h", k, got, exp_w[k]); end
    end
    nvec++; if (fdcnt2 != 1) begin nfail++; $display("FAIL frame_done_count: got %0d want 1", fdcnt2); end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [15:0] got, ex;
    logic [63:0] g1;
    g1 = 64'h8877_6655_4433_2211;
    wq2.delete(); fdcnt2 = 0;
    grid2 = g1;
    update2 = 1'b1; tick(); update2 = 1'b0;
    repeat (10) tick();
    grid2 = 64'hFFEE_DDCC_BBAA_9988;
    wait_idle2(2000, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL snap_timeout: busy %b want 0", busy2); end
    for (int r = 0; r < 8; r++) begin
      ex = {8'(r + 1), g1[8*r +: 8]};
      got = (r < wq2.size()) ? wq2[r] : 16'hxxxx;
      nvec++; if (got !== ex) begin nfail++; $display("FAIL snap_word%0d: got %h want %h", r, got, ex); end
    end
    repeat (100) tick();
    nvec++; if (busy2 !== 1'b0) begin nfail++; $display("FAIL snap_no_restart_busy: got %b want 0", busy2); end
    nvec++; if (wq2.size() != 8) begin nfail++; $display("FAIL snap_no_restart_words: got %0d want 8", wq2.size()); end
    nvec++; if (fdcnt2 != 1) begin nfail++; $display("FAIL snap_done_count: got %0d want 1", fdcnt2); end
  endtask

  task automatic test_back_to_back();
    bit ok, seen, drop, reached;
    int dt;
    logic [15:0] got, ex;
    logic [63:0] ga, gb;
    ga = 64'h0102_0408_1020_4080;
    gb = 64'hF0E0_D0C0_B0A0_9080;
    wq2.delete(); fdt2.delete(); fdcnt2 = 0;
    seen = 1'b0; drop = 1'b0; reached = 1'b0;
    grid2 = ga;
    update2 = 1'b1; tick(); update2 = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      tick();
      if (i == 20 || i == 60 || i == 100) update2 = 1'b1;
      if (i == 21 || i == 61 || i == 101) update2 = 1'b0;
      if (i == 200) grid2 = gb;
      if (busy2 === 1'b1) seen = 1'b1;
      else if (seen) drop = 1'b1;
      if (fdcnt2 >= 2) reached = 1'b1;
    end
    nvec++; if (!reached) begin nfail++; $display("FAIL b2b_timeout: frames %0d want 2", fdcnt2); end
    nvec++; if (drop) begin nfail++; $display("FAIL b2b_busy_gap: busy dropped between frames, want steady 1"); end
    dt = (fdt2.size() >= 2) ? fdt2[1] - fdt2[0] : -1;
    nvec++; if (dt != 544) begin nfail++; $display("FAIL b2b_period: got %0d want 544", dt); end
    wait_idle2(2000, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL b2b_idle_timeout: busy %b want 0", busy2); end
    repeat (20) tick();
    nvec++; if (fdcnt2 != 2) begin nfail++; $display("FAIL b2b_frame_count: got %0d want 2", fdcnt2); end
    nvec++; if (wq2.size() != 16) begin nfail++; $display("FAIL b2b_word_count: got %0d want 16", wq2.size()); end
    for (int k = 0; k < 16; k++) begin
      ex = (k < 8) ? {8'(k + 1), ga[8*k +: 8]} : {8'(k - 7), gb[8*(k-8) +: 8]};
      got = (k < wq2.size()) ? wq2[k] : 16'hxxxx;
      nvec++; if (got !== ex) begin nfail++; $display("FAIL b2b_word%0d: got %h want %h", k, got, ex); end
    end
  endtask

  task automatic test_reset_midword();
    bit ok, hit;
    logic [15:0] got;
    logic [15:0] exp2 [5];
    exp2 = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00};
    wq2.delete(); fdcnt2 = 0;
    grid2 = 64'h8877_6655_4433_2211;
    update2 = 1'b1; tick(); update2 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      if (wq2.size() == 3 && nb2 == 8) hit = 1'b1;
    end
    nvec++; if (!hit) begin nfail++; $display("FAIL midword_reach: words %0d bits %0d want 3/8", wq2.size(), nb2); end
    tick(); tick();
    nvec++; if (spi2.cs_n !== 1'b0 || spi2.sck !== 1'b0) begin nfail++; $display("FAIL midword_pre: cs_n %b sck %b want 0 0", spi2.cs_n, spi2.sck); end
    rst2 = 1'b1;
    #1;
    nvec++; if (spi2.cs_n !== 1'b1) begin nfail++; $display("FAIL midword_cs_n: got %b want 1", spi2.cs_n); end
    nvec++; if (spi2.sck !== 1'b0) begin nfail++; $display("FAIL midword_sck: got %b want 0", spi2.sck); end
    repeat (3) tick();
    wq2.delete(); lq2.delete();
    rst2 = 1'b0;
    wait_idle2(1000, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL midword_init_timeout: busy %b want 0", busy2); end
    for (int k = 0; k < 5; k++) begin
      got = (k < wq2.size()) ? wq2[k] : 16'hxxxx;
      nvec++; if (got !== exp2[k]) begin nfail++; $display("FAIL midword_init%0d: got %h want %h", k, got, exp2[k]); end
    end
    repeat (50) tick();
    nvec++; if (busy2 !== 1'b0 || wq2.size() != 5) begin nfail++; $display("FAIL midword_after: busy %b words %0d want 0 5", busy2, wq2.size()); end
  endtask

  task automatic test_clkdiv1();
    bit seen, drop, reached, ok;
    int dt;
    logic [15:0] got, ex;
    logic [63:0] g3;
    g3 = 64'h0123_4567_89AB_CDEF;
    wq1.delete(); lq1.delete(); fdt1.delete(); fdcnt1 = 0;
    seen = 1'b0; drop = 1'b0; reached = 1'b0;
    grid1 = g3;
    update1 = 1'b1;
    for (int i = 0; i < 3000 && !reached; i++) begin
      tick();
      if (busy1 === 1'b1) seen = 1'b1;
      else if (seen) drop = 1'b1;
      if (fdcnt1 >= 4) reached = 1'b1;
    end
    update1 = 1'b0;
    nvec++; if (!reached) begin nfail++; $display("FAIL div1_timeout: frames %0d want 4", fdcnt1); end
    nvec++; if (drop) begin nfail++; $display("FAIL div1_busy_gap: busy dropped, want steady 1"); end
    for (int k = 0; k < 3; k++) begin
      dt = (k + 1 < fdt1.size()) ? fdt1[k+1] - fdt1[k] : -1;
      nvec++; if (dt != 272) begin nfail++; $display("FAIL div1_period%0d: got %0d want 272", k, dt); end
    end
    for (int r = 0; r < 8; r++) begin
      ex = {8'(r + 1), g3[8*r +: 8]};
      got = (r < wq1.size()) ? wq1[r] : 16'hxxxx;
      nvec++; if (got !== ex) begin nfail++; $display("FAIL div1_word%0d: got %h want %h", r, got, ex); end
    end
    nvec++; if (lq1.size() == 0 || lq1[0] != 33) begin nfail++; $display("FAIL div1_cs_window: got %0d want 33", (lq1.size() > 0) ? lq1[0] : -1); end
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (busy1 === 1'b0) ok = 1'b1;
    end
    nvec++; if (!ok) begin nfail++; $display("FAIL div1_idle: busy %b want 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_back_to_back();
    test_reset_midword();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
